// File: rtl/mem_arbiter.sv
// Single-port arbiter that serializes IF word fetches and MEM byte/half/word accesses onto an 8-bit RAM.
// Build option MEM_ARB_ABORT_EN: a MEM request preempts an IF fetch that is still in BUSY.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [2:0]        len_q, len_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic [31:0]       asm_cap;
    logic              grant_mem, grant_if;

    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        ram_a       = '0;
        ram_dout    = '0;
        ram_wr      = 1'b0;
        grant_mem   = 1'b0;
        grant_if    = 1'b0;

        // Byte arriving now belongs to the address issued one cycle earlier (cnt-1).
        asm_cap = asm_q;
        case (cnt_q)
            3'd1:    asm_cap[7:0]   = ram_din;
            3'd2:    asm_cap[15:8]  = ram_din;
            3'd3:    asm_cap[23:16] = ram_din;
            3'd4:    asm_cap[31:24] = ram_din;
            default: ;
        endcase

        case (state_q)
            IDLE: begin
                grant_mem = mem_req;
                grant_if  = ~mem_req & if_req;
            end
            BUSY: begin
                ram_a = base_q + ADDR_W'(cnt_q);
                cnt_d = cnt_q + 3'd1;
                if (we_q) begin
                    ram_wr = 1'b1;
                    case (cnt_q[1:0])
                        2'd0:    ram_dout = wdata_q[7:0];
                        2'd1:    ram_dout = wdata_q[15:8];
                        2'd2:    ram_dout = wdata_q[23:16];
                        default: ram_dout = wdata_q[31:24];
                    endcase
                    if (cnt_q == len_q - 3'd1) begin
                        state_d    = DONE;
                        mem_done_d = 1'b1;
                    end
                end else begin
                    asm_d = asm_cap;
                    if (cnt_q == len_q) begin
                        state_d = DONE;
                        if (owner_q == OWN_MEM) begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = asm_cap;
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = asm_cap;
                        end
                    end
                end
`ifdef MEM_ARB_ABORT_EN
                grant_mem = (owner_q == OWN_IF) & mem_req;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A MEM grant out of BUSY abandons the IF fetch, so its completion is suppressed.
        if (grant_mem) begin
            state_d   = BUSY;
            owner_d   = OWN_MEM;
            we_d      = mem_we;
            len_d     = size_to_len(mem_size);
            base_d    = mem_addr;
            wdata_d   = mem_wdata;
            cnt_d     = '0;
            asm_d     = '0;
            if_done_d = 1'b0;
            if_data_d = if_data_q;
        end else if (grant_if) begin
            state_d = BUSY;
            owner_d = OWN_IF;
            we_d    = 1'b0;
            len_d   = 3'd4;
            base_d  = if_addr;
            cnt_d   = '0;
            asm_d   = '0;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = mem_req & ~mem_done_q;

endmodule
